uart_axi_lite: RTL and testbench

//  AXI4-Lite slave wrapping a full-duplex 8-bit UART (TX + RX). Sits on the processor

---
 rtl/uart_axi_lite_if.sv | 60 ++++++
 rtl/uart_axi_lite.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_axi_lite.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axi_lite_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_axi_lite_if
//  Purpose  : AXI4-Lite bus bundle between a processor-side master and the
//             uart_axi_lite peripheral.
//  Ports    : none (signal bundle only)
//             master modport - drives AW/W/AR address, data and valid
//                              signals plus bready/rready.
//             slave modport  - drives the ready signals and the B/R
//                              response channels.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_axi_lite_if;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/uart_axi_lite.sv
`default_nettype none
// ============================================================================
//  Module   : uart_axi_lite
//  Purpose  : AXI4-Lite slave wrapping a full-duplex 8-bit UART with a
//             single byte buffer in each direction. Frame: start(0),
//             8 data bits LSB first, parity, stop(1).
//  Ports    : s_axi_aclk   - clock, rising edge
//             s_axi_areset - asynchronous active-high reset
//             axi          - AXI4-Lite slave bundle (uart_axi_lite_if.slave)
//             rx_in        - serial receive line (asynchronous, idle high)
//             tx_out       - serial transmit line (idle high)
//  Registers: 0x0 TX_DATA (W), 0x4 RX_DATA (R), 0x8 STATUS (R),
//             0xC CONTROL (W, reads 0)
//  Revision : 1.0  initial release
// ============================================================================
module uart_axi_lite #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter bit PARITY        = 1'b1,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_areset,
    uart_axi_lite_if.slave  axi,
    input  logic            rx_in,
    output logic            tx_out
);

    localparam int c_bit_cyc = CLK_FREQUENCY / BAUD_RATE;
    localparam int c_cnt_w   = $clog2(c_bit_cyc + 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_bit_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_bit_cyc / 2 - 1);

    localparam logic [1:0] c_reg_tx     = 2'd0;
    localparam logic [1:0] c_reg_rx     = 2'd1;
    localparam logic [1:0] c_reg_status = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                r_awready;
    logic                r_bvalid;
    logic                r_arready;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rd_data;
    logic [31:0]         w_status;

    logic                r_tx_busy;
    logic [10:0]         r_tx_shift;
    logic [c_cnt_w-1:0]  r_tx_cnt;
    logic [3:0]          r_tx_bit;

    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_rx_prev;
    rx_state_t           r_rx_state;
    logic [c_cnt_w-1:0]  r_rx_cnt;
    logic [2:0]          r_rx_bit;
    logic [7:0]          r_rx_shift;
    logic                r_rx_par;
    logic [7:0]          r_rx_byte;
    logic                r_rx_valid;
    logic                r_parity_err;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_wr_fire;
    logic                w_wr_en;
    logic                w_tx_start;
    logic                w_ctrl_clear;
    logic                w_rd_fire;
    logic                w_rx_read;
    logic                w_unused_bits;

    // ------------------------------------------------------------------
    // AXI write channel: AW and W are only accepted together
    // ------------------------------------------------------------------
    assign axi.s_axi_awready = r_awready;
    assign axi.s_axi_wready  = r_awready;
    assign axi.s_axi_bvalid  = r_bvalid;
    assign axi.s_axi_bresp   = 2'b00;

    assign w_wr_fire    = r_awready & axi.s_axi_awvalid & axi.s_axi_wvalid;
    assign w_wr_en      = w_wr_fire & axi.s_axi_wstrb[0];
    assign w_tx_start   = w_wr_en && (axi.s_axi_awaddr[3:2] == c_reg_tx) && !r_tx_busy;
    assign w_ctrl_clear = w_wr_en && (axi.s_axi_awaddr[3:2] == c_reg_ctrl) && axi.s_axi_wdata[0];

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            // ready is a single-cycle pulse; the !r_awready term stops a
            // second acceptance while the handshake edge is still pending
            r_awready <= axi.s_axi_awvalid && axi.s_axi_wvalid && !r_bvalid && !r_awready;
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            else if (r_bvalid && axi.s_axi_bready)
                r_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // AXI read channel: data captured at address acceptance
    // ------------------------------------------------------------------
    assign axi.s_axi_arready = r_arready;
    assign axi.s_axi_rvalid  = r_rvalid;
    assign axi.s_axi_rdata   = r_rdata;
    assign axi.s_axi_rresp   = 2'b00;

    assign w_rd_fire = r_arready & axi.s_axi_arvalid;
    assign w_rx_read = w_rd_fire && (axi.s_axi_araddr[3:2] == c_reg_rx);
    assign w_status  = {27'd0, r_overrun, r_frame_err, r_parity_err, r_rx_valid, r_tx_busy};

    always_comb begin
        w_rd_data = 32'd0;
        case (axi.s_axi_araddr[3:2])
            c_reg_rx:     w_rd_data = {24'd0, r_rx_byte};
            c_reg_status: w_rd_data = w_status;
            default:      w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= axi.s_axi_arvalid && !r_rvalid && !r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && axi.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter: shift register holds the remaining frame, LSB first;
    // tx_out always presents the bit currently on the line
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            tx_out     <= 1'b1;
        end else if (!r_tx_busy) begin
            if (w_tx_start) begin
                r_tx_busy  <= 1'b1;
                r_tx_shift <= {1'b1, (^axi.s_axi_wdata[7:0]) ^ PARITY,
                               axi.s_axi_wdata[7:0], 1'b0};
                r_tx_cnt   <= '0;
                r_tx_bit   <= 4'd0;
                tx_out     <= 1'b0;
            end
        end else if (r_tx_cnt == c_bit_last) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd10) begin
                r_tx_busy <= 1'b0;
                tx_out    <= 1'b1;
            end else begin
                r_tx_bit   <= r_tx_bit + 4'd1;
                r_tx_shift <= {1'b1, r_tx_shift[10:1]};
                tx_out     <= r_tx_shift[1];
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver: two-flop synchronizer plus one history flop so that IDLE
    // reacts to a genuine falling edge rather than a line held low
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Status flags live here too so that bus clears and frame completion
    // resolve in one place; completion is evaluated last and therefore
    // wins over a same-cycle RX_DATA read.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_rx_par     <= 1'b0;
            r_rx_byte    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_rx_read)
                r_rx_valid <= 1'b0;
            if (w_ctrl_clear) begin
                r_parity_err <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
            end

            case (r_rx_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= S_PARITY;
                        else
                            r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= r_rx_sync;
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_byte  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        if (r_rx_valid)
                            r_overrun <= 1'b1;
                        if (r_rx_par != ((^r_rx_shift) ^ PARITY))
                            r_parity_err <= 1'b1;
                        if (!r_rx_sync)
                            r_frame_err <= 1'b1;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // Bus fields with no function in this peripheral
    assign w_unused_bits = &{1'b0, axi.s_axi_awprot, axi.s_axi_arprot,
                             axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0],
                             axi.s_axi_wdata[31:8], axi.s_axi_wstrb[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_uart_axi_lite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_axi_lite
//  Purpose  : Self-checking bench for uart_axi_lite. Directed register and
//             frame checks, randomized receive traffic against a byte-level
//             status model, and a full 0x00..0xFF TX->RX loopback.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_axi_lite;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD_HZ = 100_000;
    localparam int BIT_CYC = CLK_HZ / BAUD_HZ;
    localparam bit PAR     = 1'b1;

    localparam logic [3:0] A_TX     = 4'h0;
    localparam logic [3:0] A_RX     = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [3:0] A_CTRL   = 4'hC;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic rx_bench = 1'b1;
    logic loop_en  = 1'b0;
    logic rx_in;
    logic tx_out;

    int checks = 0;
    int errors = 0;

    assign rx_in = loop_en ? tx_out : rx_bench;

    uart_axi_lite_if bus ();

    uart_axi_lite #(
        .CLK_FREQUENCY (CLK_HZ),
        .PARITY        (PAR),
        .BAUD_RATE     (BAUD_HZ)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .axi          (bus),
        .rx_in        (rx_in),
        .tx_out       (tx_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic logic par_bit(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        if (PAR) return (ones % 2 == 0);
        else     return (ones % 2 == 1);
    endfunction

    // Line levels in transmission order: index 0 = start bit
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = par_bit(b);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus tasks (entered and left on a falling clock edge)
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_axi_awready && n < 20);
        check("aw_ready", 32'(bus.s_axi_awready & bus.s_axi_wready), 32'd1);
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        n = 0;
        while (!bus.s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_valid", 32'(bus.s_axi_bvalid), 32'd1);
        resp = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.s_axi_arready && n < 20);
        check("ar_ready", 32'(bus.s_axi_arready), 32'd1);
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
        check("r_valid", 32'(bus.s_axi_rvalid), 32'd1);
        data = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [3:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        logic [1:0] resp;
        axi_write(addr, data, strb, resp);
        check({tag, "_bresp"}, 32'(resp), 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  resp;
        axi_read(addr, d, resp);
        check(tag, d, exp);
        check({tag, "_rresp"}, 32'(resp), 32'd0);
    endtask

    task automatic poll_status(input string tag, input logic [31:0] mask, input logic [31:0] want);
        logic [31:0] d;
        logic [1:0]  resp;
        int n;
        n = 0;
        do begin axi_read(A_STATUS, d, resp); n++; end
        while (((d & mask) !== want) && n < 200);
        check(tag, d & mask, want);
    endtask

    // Samples the line at each bit centre after a falling edge
    task automatic capture_frame(output logic [10:0] bits);
        int n;
        bits = '1;
        n = 0;
        while (tx_out !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        check("tx_start_seen", 32'(tx_out), 32'd0);
        repeat (BIT_CYC / 2) @(negedge clk);
        bits[0] = tx_out;
        for (int i = 1; i < 11; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            bits[i] = tx_out;
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = exp_frame(b);
        f[9]  = f[9] ^ bad_par;
        f[10] = !bad_stop;
        for (int i = 0; i < 11; i++) begin
            rx_bench = f[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_bench = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [10:0] cap_bits;
    logic [7:0]  rb;
    int          low_cnt;
    bit          m_valid, m_perr, m_ferr, m_ovr;
    logic [7:0]  m_byte;
    bit          bp, bs;

    initial begin
        bus.s_axi_awaddr  = 4'h0;
        bus.s_axi_awprot  = 3'd0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = 32'd0;
        bus.s_axi_wstrb   = 4'h0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = 4'h0;
        bus.s_axi_arprot  = 3'd0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_tx_out",  32'(tx_out), 32'd1);
        check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("rst_bvalid",  32'(bus.s_axi_bvalid), 32'd0);
        check("rst_rvalid",  32'(bus.s_axi_rvalid), 32'd0);
        check("rst_rdata",   bus.s_axi_rdata, 32'd0);
        rd_check("rst_status", A_STATUS, 32'h0);

        // TX write without byte lane 0 has no effect
        wr("tx_nostrb", A_TX, 32'h77, 4'b1110);
        rd_check("nostrb_status", A_STATUS, 32'h0);

        // 0x55 frame; 0xA5 written while busy must be dropped
        fork
            capture_frame(cap_bits);
            begin
                wr("tx_55", A_TX, 32'h55, 4'hF);
                rd_check("busy_status", A_STATUS, 32'h1);
                wr("tx_a5_busy", A_TX, 32'hA5, 4'hF);
            end
        join
        check("tx_frame_55", 32'(cap_bits), 32'(exp_frame(8'h55)));
        poll_status("tx_idle", 32'h1, 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 3 * BIT_CYC; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) low_cnt++;
        end
        check("tx_no_second_frame", 32'(low_cnt), 32'd0);

        // Clean receive of 0x3C
        drive_rx(8'h3C, 1'b0, 1'b0);
        rd_check("rx3c_status", A_STATUS, 32'h2);
        rd_check("rx3c_data",   A_RX,     32'h3C);
        rd_check("rx3c_status_after", A_STATUS, 32'h0);

        // Bad parity and bad stop, then flag clearing
        rb = 8'($urandom);
        drive_rx(rb, 1'b1, 1'b1);
        rd_check("err_status", A_STATUS, 32'hE);
        rd_check("err_data",   A_RX,     32'(rb));
        rd_check("err_status_read", A_STATUS, 32'hC);
        wr("ctrl_nostrb", A_CTRL, 32'h1, 4'h0);
        rd_check("ctrl_nostrb_status", A_STATUS, 32'hC);
        wr("ctrl_zero", A_CTRL, 32'h0, 4'h1);
        rd_check("ctrl_zero_status", A_STATUS, 32'hC);
        wr("ctrl_clear", A_CTRL, 32'h1, 4'h1);
        rd_check("ctrl_clear_status", A_STATUS, 32'h0);
        rd_check("ctrl_read", A_CTRL, 32'h0);

        // Randomized receive traffic against a byte-level model
        m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_byte = rb;
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            bp = ($urandom_range(3) == 0);
            bs = ($urandom_range(3) == 0);
            drive_rx(rb, bp, bs);
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = rb;
            if (bp) m_perr = 1'b1;
            if (bs) m_ferr = 1'b1;
            rd_check("rand_status", A_STATUS, {27'd0, m_ovr, m_ferr, m_perr, m_valid, 1'b0});
            if ($urandom_range(1) == 1) begin
                rd_check("rand_data", A_RX, 32'(m_byte));
                m_valid = 1'b0;
            end
            if ($urandom_range(2) == 0) begin
                wr("rand_clear", A_CTRL, 32'h1, 4'h1);
                m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end
        end
        rd_check("rand_final_data", A_RX, 32'(m_byte));
        wr("rand_final_clear", A_CTRL, 32'h1, 4'h1);
        rd_check("rand_final_status", A_STATUS, 32'h0);

        // Loopback of every byte value
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 256; b++) begin
            wr("loop_tx", A_TX, 32'(b), 4'h1);
            poll_status("loop_done", 32'h3, 32'h2);
            rd_check("loop_status", A_STATUS, 32'h2);
            rd_check("loop_data",   A_RX,     32'(b));
        end
        rd_check("loop_end_status", A_STATUS, 32'h0);

        // Two bytes unread -> overrun, latest byte kept
        wr("ovr_tx1", A_TX, 32'h5A, 4'h1);
        poll_status("ovr_first", 32'h3, 32'h2);
        wr("ovr_tx2", A_TX, 32'hC3, 4'h1);
        poll_status("ovr_second", 32'h11, 32'h10);
        rd_check("ovr_status", A_STATUS, 32'h12);
        rd_check("ovr_data",   A_RX,     32'hC3);
        rd_check("ovr_status_read", A_STATUS, 32'h10);
        wr("ovr_clear", A_CTRL, 32'h1, 4'h1);
        rd_check("ovr_cleared", A_STATUS, 32'h0);
        loop_en = 1'b0;

        // Asynchronous reset in the middle of a frame (0xF0: bit d1 is 0)
        wr("abort_tx", A_TX, 32'hF0, 4'h1);
        repeat (2 * BIT_CYC + BIT_CYC / 2 - 4) @(negedge clk);
        check("abort_mid_low", 32'(tx_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_tx_high", 32'(tx_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_check("abort_status", A_STATUS, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
